// File: rtl/tinyriscv_pkg.sv
// Core-wide bus widths, constants and fetch bundle types.
// Shared by the fetch unit and its buffers.
package tinyriscv_pkg;

    localparam int InstBus     = 32;
    localparam int InstAddrBus = 32;

    localparam logic [InstBus-1:0] INST_NOP = 32'h0000_0013;

    localparam int IfuDepth = 2;

    typedef struct packed {
        logic [InstBus-1:0]     inst;
        logic [InstAddrBus-1:0] addr;
    } fetch_entry_t;

endpackage

// File: rtl/ifu_prefetch_if.sv
// Instruction bus: request/grant, then in-order read responses.
// The fetch unit is the master, memory the slave.
interface ifu_prefetch_if;
    import tinyriscv_pkg::*;

    logic                   req;
    logic [InstAddrBus-1:0] addr;
    logic                   gnt;
    logic                   rvalid;
    logic [InstBus-1:0]     rdata;

    modport master (
        output req,
        output addr,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output gnt,
        output rvalid,
        output rdata
    );

endinterface

// File: rtl/ifu_fifo.sv
// Small synchronous FIFO with flush, used for fetch data and addresses.
// Pointers carry an extra wrap bit to tell full from empty.
module ifu_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr == rd_ptr);
    assign full_o  = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count_o = wr_ptr - rd_ptr;
    assign data_o  = mem[rd_ptr[AW-1:0]];

    // A push into a full FIFO is only taken together with a pop.
    assign do_push = push_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && !flush_i && do_push) begin
            mem[wr_ptr[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction prefetch: issues bus fetches, buffers returned words,
// and presents them to decode; flushes and redirects on jump.
module ifu_prefetch
    import tinyriscv_pkg::*;
#(
    parameter int                     DEPTH      = IfuDepth,
    parameter logic [InstAddrBus-1:0] RESET_ADDR = 32'h0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   jump_flag_i,
    input  logic [InstAddrBus-1:0] jump_addr_i,
    input  logic                   hold_i,
    ifu_prefetch_if.master         ibus,
    output logic [InstBus-1:0]     inst_o,
    output logic [InstAddrBus-1:0] inst_addr_o,
    output logic                   inst_valid_o
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0]   CAP = (CW+1)'(DEPTH);
    localparam logic [CW-1:0] ONE = CW'(1);

    logic [InstAddrBus-1:0] pc;
    logic [CW-1:0]          outstanding;
    logic [CW-1:0]          discard;
    logic [CW-1:0]          buf_count;
    logic [CW-1:0]          aq_count;
    logic                   buf_empty;
    logic                   buf_full;
    logic                   aq_empty;
    logic                   aq_full;
    logic [InstAddrBus-1:0] aq_head;
    fetch_entry_t           head;
    fetch_entry_t           push_entry;
    logic [CW:0]            in_use;
    logic                   accept;
    logic                   rsp;
    logic                   keep;
    logic                   pop;
    logic                   ifu_unused;

    // Words still to be discarded stay in outstanding, so they hold credit.
    assign in_use = {1'b0, buf_count} + {1'b0, outstanding};

    assign ibus.req  = rst_n && !jump_flag_i && (in_use < CAP);
    assign ibus.addr = pc;

    assign accept = ibus.req && ibus.gnt;
    assign rsp    = ibus.rvalid && (outstanding != '0);
    assign keep   = rsp && (discard == '0) && !jump_flag_i;
    assign pop    = inst_valid_o && !hold_i && !jump_flag_i;

    assign push_entry = '{inst: ibus.rdata, addr: aq_head};

    assign ifu_unused = ^{aq_count, aq_full, aq_empty,
                          buf_full, jump_addr_i[1:0]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc <= RESET_ADDR;
        end else if (jump_flag_i) begin
            pc <= {jump_addr_i[InstAddrBus-1:2], 2'b00};
        end else if (accept) begin
            pc <= pc + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            outstanding <= '0;
        end else begin
            outstanding <= outstanding + CW'(accept) - CW'(rsp);
        end
    end

    // Everything in flight at a jump belongs to the old stream.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            discard <= '0;
        end else if (jump_flag_i) begin
            discard <= outstanding - CW'(rsp);
        end else if (rsp && (discard != '0)) begin
            discard <= discard - ONE;
        end
    end

    ifu_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (InstAddrBus)
    ) u_addr_q (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (jump_flag_i),
        .push_i  (accept),
        .data_i  (pc),
        .pop_i   (keep),
        .data_o  (aq_head),
        .full_o  (aq_full),
        .empty_o (aq_empty),
        .count_o (aq_count)
    );

    ifu_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (jump_flag_i),
        .push_i  (keep),
        .data_i  (push_entry),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (buf_full),
        .empty_o (buf_empty),
        .count_o (buf_count)
    );

    assign inst_valid_o = !buf_empty;
    assign inst_o       = inst_valid_o ? head.inst : INST_NOP;
    assign inst_addr_o  = inst_valid_o ? head.addr : '0;

endmodule

// File: tb/tb_ifu_prefetch.sv
// Bench for ifu_prefetch: random bus slave, stream-level reference
// model and a scoreboard of expected fetch addresses.
module tb_ifu_prefetch;
    import tinyriscv_pkg::*;

    localparam int DEPTH = IfuDepth;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          gcyc;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        jump_flag;
    logic [31:0] jump_addr;
    logic        hold;
    logic [31:0] inst;
    logic [31:0] inst_addr;
    logic        inst_valid;

    ifu_prefetch_if bus ();

    ifu_prefetch #(
        .DEPTH      (DEPTH),
        .RESET_ADDR (32'h0)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .jump_flag_i  (jump_flag),
        .jump_addr_i  (jump_addr),
        .hold_i       (hold),
        .ibus         (bus),
        .inst_o       (inst),
        .inst_addr_o  (inst_addr),
        .inst_valid_o (inst_valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // 0: always, 1: random, 2: never
    int gnt_mode = 0;
    int rv_mode  = 0;

    txn_t        slave_q[$];
    logic        cur_rv = 1'b0;
    txn_t        cur_rsp;
    logic [31:0] exp_q[$];
    logic [31:0] m_pc = 32'h0;
    int          epoch = 0;
    int          buf_words = 0;
    int          grants = 0;
    int          consumed = 0;
    logic        rst_seen = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Bus slave: in-order responses at least one cycle after grant
    initial begin
        bus.gnt    = 1'b0;
        bus.rvalid = 1'b0;
        bus.rdata  = 32'h0;
        forever begin
            @(posedge clk);
            #2;
            case (gnt_mode)
                0:       bus.gnt = 1'b1;
                1:       bus.gnt = 1'($urandom_range(0, 1));
                default: bus.gnt = 1'b0;
            endcase
            cur_rv = 1'b0;
            if (rst_n && slave_q.size() > 0 && slave_q[0].gcyc < cyc) begin
                if (rv_mode == 0 ||
                    (rv_mode == 1 && $urandom_range(0, 1) == 1)) begin
                    cur_rsp = slave_q.pop_front();
                    cur_rv  = 1'b1;
                end
            end
            bus.rvalid = cur_rv;
            bus.rdata  = cur_rv ? mem_word(cur_rsp.addr) : $urandom;
        end
    end

    // Monitor and reference model
    always @(negedge clk) begin
        int   occ;
        logic exp_req;
        logic take;
        logic fresh;
        if (!rst_n) begin
            if (rst_seen) begin
                check("rst_req", 32'(bus.req), 32'h0);
                check("rst_addr", bus.addr, 32'h0);
                check("rst_valid", 32'(inst_valid), 32'h0);
                check("rst_inst", inst, INST_NOP);
                check("rst_inst_addr", inst_addr, 32'h0);
            end
            rst_seen = 1'b1;
            slave_q.delete();
            exp_q.delete();
            m_pc      = 32'h0;
            buf_words = 0;
            epoch++;
        end else begin
            rst_seen = 1'b0;
            occ = slave_q.size() + (cur_rv ? 1 : 0) + buf_words;
            exp_req = !jump_flag && (occ < DEPTH);
            check("req", 32'(bus.req), 32'(exp_req));
            if (exp_req) check("fetch_addr", bus.addr, m_pc);
            check("valid", 32'(inst_valid), 32'(buf_words > 0));
            if (buf_words > 0 && exp_q.size() > 0) begin
                check("head_addr", inst_addr, exp_q[0]);
                check("head_inst", inst, mem_word(exp_q[0]));
            end else begin
                check("idle_inst", inst, INST_NOP);
                check("idle_addr", inst_addr, 32'h0);
            end
            take  = (buf_words > 0) && !hold && !jump_flag;
            fresh = cur_rv && !jump_flag && (cur_rsp.epoch == epoch);
            if (bus.req && bus.gnt) begin
                slave_q.push_back('{addr: bus.addr, epoch: epoch,
                                    gcyc: cyc});
                exp_q.push_back(m_pc);
                m_pc = m_pc + 32'd4;
                grants++;
            end
            if (fresh) buf_words++;
            if (take) begin
                void'(exp_q.pop_front());
                buf_words--;
                consumed++;
            end
            if (jump_flag) begin
                epoch++;
                exp_q.delete();
                buf_words = 0;
                m_pc = {jump_addr[31:2], 2'b00};
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        jump_flag = 1'b0;
        hold      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_outstanding(input int n);
        int k = 0;
        while (slave_q.size() < n && k < 30) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("wait_outstanding", 32'(slave_q.size() >= n), 32'h1);
    endtask

    task automatic wait_valid();
        int k = 0;
        while (!inst_valid && k < 30) begin
            @(negedge clk);
            k++;
        end
        check("wait_valid", 32'(inst_valid), 32'h1);
    endtask

    initial begin
        int g0;
        int c0;
        rst_n     = 1'b0;
        jump_flag = 1'b0;
        jump_addr = 32'h0;
        hold      = 1'b0;

        // Streaming after reset and first-word latency
        gnt_mode = 0;
        rv_mode  = 0;
        do_reset();
        @(negedge clk);
        check("t1_req_c0", 32'(bus.req), 32'h1);
        check("t1_addr_c0", bus.addr, 32'h0);
        check("t1_valid_c0", 32'(inst_valid), 32'h0);
        @(negedge clk);
        check("t1_valid_c1", 32'(inst_valid), 32'h0);
        @(negedge clk);
        check("t1_valid_c2", 32'(inst_valid), 32'h1);
        check("t1_addr_c2", inst_addr, 32'h0);
        check("t1_inst_c2", inst, mem_word(32'h0));
        c0 = consumed;
        repeat (30) @(negedge clk);
        check("t1_streamed", 32'(consumed - c0 >= 10), 32'h1);

        // Request held stable while not granted
        gnt_mode = 2;
        do_reset();
        repeat (3) begin
            @(negedge clk);
            check("t2_req_stall", 32'(bus.req), 32'h1);
            check("t2_addr_stall", bus.addr, 32'h0);
        end
        @(posedge clk);
        #1;
        gnt_mode = 0;
        @(negedge clk);
        check("t2_addr_gnt", bus.addr, 32'h0);
        @(negedge clk);
        check("t2_req_next", 32'(bus.req), 32'h1);
        check("t2_addr_next", bus.addr, 32'h4);

        // Hold with a responsive bus
        repeat (5) @(posedge clk);
        #1;
        hold = 1'b1;
        g0 = grants;
        repeat (5) @(posedge clk);
        #1;
        check("t3_hold_grants", 32'(grants - g0 <= DEPTH), 32'h1);
        hold = 1'b0;
        repeat (15) @(posedge clk);
        #1;

        // Jump with two fetches outstanding
        rv_mode = 2;
        wait_outstanding(2);
        jump_flag = 1'b1;
        jump_addr = 32'h100;
        @(posedge clk);
        #1;
        jump_flag = 1'b0;
        rv_mode   = 0;
        wait_valid();
        check("t4_first_addr", inst_addr, 32'h100);
        repeat (10) @(posedge clk);
        #1;

        // Jump, response and hold in the same cycle
        rv_mode = 2;
        do_reset();
        hold = 1'b1;
        wait_outstanding(2);
        rv_mode   = 0;
        jump_flag = 1'b1;
        jump_addr = 32'h100;
        @(posedge clk);
        #1;
        jump_flag = 1'b0;
        @(negedge clk);
        check("t5_valid_after", 32'(inst_valid), 32'h0);
        check("t5_req_after", 32'(bus.req), 32'h1);
        check("t5_addr_after", bus.addr, 32'h100);
        @(posedge clk);
        #1;
        hold = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        // Address wrap, then reset mid-stream
        jump_flag = 1'b1;
        jump_addr = 32'hFFFF_FFFE;
        @(posedge clk);
        #1;
        jump_flag = 1'b0;
        wait_valid();
        check("t6_wrap_hi", inst_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        wait_valid();
        check("t6_wrap_lo", inst_addr, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t6_rst_req", 32'(bus.req), 32'h0);
        check("t6_rst_valid", 32'(inst_valid), 32'h0);
        check("t6_rst_inst", inst, INST_NOP);
        check("t6_rst_addr", inst_addr, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Random traffic
        gnt_mode = 1;
        rv_mode  = 1;
        c0 = consumed;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            hold      = ($urandom_range(0, 3) == 0);
            jump_flag = ($urandom_range(0, 39) == 0);
            jump_addr = $urandom;
        end
        @(posedge clk);
        #1;
        jump_flag = 1'b0;
        hold      = 1'b0;
        repeat (5) @(posedge clk);
        check("rand_progress", 32'(consumed - c0 > 100), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
